// File: rtl/rr_slot_arbiter.sv
// Round-robin slot arbiter: shares one resource among N requesters, each
// grant bounded to QUANTUM cycles, with one dead cycle between grants.
module rr_slot_arbiter #(
    parameter int N       = 5,
    parameter int PTR_W   = 3,
    parameter int QUANTUM = 5,
    parameter int CNT_W   = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] owner,
    output logic             busy,
    output logic [CNT_W-1:0] hold_count,
    output logic             timeout
);

    localparam logic [0:0]       ST_IDLE   = 1'b0;
    localparam logic [0:0]       ST_GRANT  = 1'b1;
    localparam logic [PTR_W-1:0] LAST_INIT = PTR_W'(N - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(QUANTUM - 1);
    localparam logic [PTR_W:0]   N_EXT     = (PTR_W + 1)'(N);

    logic [0:0]       state;
    logic [PTR_W-1:0] last;
    logic [PTR_W-1:0] pick;
    logic             pick_vld;
    logic [PTR_W:0]   search_idx;

    // Round-robin search: first pending requester after the last one served.
    // The extra index bit holds last+i (at most 2N-1) before the modulo-N wrap.
    always_comb begin
        pick       = last;
        pick_vld   = 1'b0;
        search_idx = '0;
        for (int i = 1; i <= N; i++) begin
            search_idx = {1'b0, last} + (PTR_W + 1)'(i);
            if (search_idx >= N_EXT) begin
                search_idx = search_idx - N_EXT;
            end
            if (!pick_vld && req[search_idx[PTR_W-1:0]]) begin
                pick     = search_idx[PTR_W-1:0];
                pick_vld = 1'b1;
            end
        end
    end

    // Grant FSM: grant on IDLE pick, release on owner drop or quantum expiry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            grant      <= '0;
            owner      <= '0;
            last       <= LAST_INIT;
            busy       <= 1'b0;
            hold_count <= '0;
            timeout    <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        state      <= ST_GRANT;
                        grant      <= N'(1) << pick;
                        owner      <= pick;
                        last       <= pick;
                        busy       <= 1'b1;
                        hold_count <= '0;
                    end
                end
                default: begin
                    // Voluntary release wins over expiry, so no timeout then.
                    if (!req[owner]) begin
                        state      <= ST_IDLE;
                        grant      <= '0;
                        busy       <= 1'b0;
                        hold_count <= '0;
                    end else if (hold_count == HOLD_MAX) begin
                        state      <= ST_IDLE;
                        grant      <= '0;
                        busy       <= 1'b0;
                        hold_count <= '0;
                        timeout    <= 1'b1;
                    end else begin
                        hold_count <= hold_count + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_slot_arbiter.sv
// Bench for rr_slot_arbiter: directed scenarios with literal expectations,
// then randomized requests, all compared against a behavioural model.
module tb_rr_slot_arbiter;

    localparam int N       = 5;
    localparam int PTR_W   = 3;
    localparam int QUANTUM = 5;
    localparam int CNT_W   = 3;

    logic             clock = 1'b0;
    logic             reset;
    logic [N-1:0]     req;
    logic [N-1:0]     grant;
    logic [PTR_W-1:0] owner;
    logic             busy;
    logic [CNT_W-1:0] hold_count;
    logic             timeout;

    int checks = 0;
    int fails  = 0;
    bit cmp_en = 1'b0;

    // Model state: age < 0 means no grant outstanding.
    int m_owner = 0;
    int m_last  = N - 1;
    int m_age   = -1;
    bit m_to    = 1'b0;

    always #5 clock = ~clock;

    rr_slot_arbiter #(
        .N(N), .PTR_W(PTR_W), .QUANTUM(QUANTUM), .CNT_W(CNT_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req(req),
        .grant(grant),
        .owner(owner),
        .busy(busy),
        .hold_count(hold_count),
        .timeout(timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One arbitration decision from the rules: who gets served next, how long.
    function automatic void model_step(input logic [N-1:0] r, input int owner_i, input int last_i,
                                       input int age_i, output int owner_o, output int last_o,
                                       output int age_o, output bit to_o);
        int c;
        owner_o = owner_i;
        last_o  = last_i;
        age_o   = age_i;
        to_o    = 1'b0;
        if (age_i < 0) begin
            for (int d = 1; d <= N; d++) begin
                c = (last_i + d) % N;
                if (age_o < 0 && (r & (N'(1) << c)) != '0) begin
                    owner_o = c;
                    last_o  = c;
                    age_o   = 0;
                end
            end
        end else if ((r & (N'(1) << owner_i)) == '0) begin
            age_o = -1;
        end else if (age_i == QUANTUM - 1) begin
            age_o = -1;
            to_o  = 1'b1;
        end else begin
            age_o = age_i + 1;
        end
    endfunction

    // Model advances on the same edges as the DUT and resets asynchronously.
    always @(posedge clock or negedge reset) begin
        int no, nl, na;
        bit nt;
        if (!reset) begin
            m_owner <= 0;
            m_last  <= N - 1;
            m_age   <= -1;
            m_to    <= 1'b0;
        end else begin
            model_step(req, m_owner, m_last, m_age, no, nl, na, nt);
            m_owner <= no;
            m_last  <= nl;
            m_age   <= na;
            m_to    <= nt;
        end
    end

    // Every-cycle compare of DUT outputs against the model, away from the edge.
    always @(negedge clock) begin
        if (cmp_en) begin
            check("grant", 32'(grant), (m_age >= 0) ? 32'(N'(1) << m_owner) : 32'd0);
            check("owner", 32'(owner), 32'(m_owner));
            check("busy", 32'(busy), (m_age >= 0) ? 32'd1 : 32'd0);
            check("hold_count", 32'(hold_count), (m_age >= 0) ? 32'(m_age) : 32'd0);
            check("timeout", 32'(timeout), 32'(m_to));
            check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
            check("owner_range", 32'(owner < PTR_W'(N)), 32'd1);
        end
    end

    task automatic cyc(input logic [N-1:0] r);
        req = r;
        @(negedge clock);
    endtask

    initial begin
        logic [N-1:0] r;
        reset = 1'b0;
        req   = '0;
        @(negedge clock);
        @(negedge clock);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_hold", 32'(hold_count), 32'd0);
        cmp_en = 1'b1;
        reset  = 1'b1;
        repeat (5) cyc('0);
        check("idle_grant", 32'(grant), 32'd0);

        // Single short request
        cyc(5'b00100);
        check("short_grant", 32'(grant), 32'b00100);
        check("short_hc0", 32'(hold_count), 32'd0);
        cyc(5'b00100);
        cyc(5'b00100);
        check("short_hc2", 32'(hold_count), 32'd2);
        cyc('0);
        check("short_drop", 32'(grant), 32'd0);
        check("short_noto", 32'(timeout), 32'd0);
        cyc('0);

        // Quantum expiry with a lone requester, then async reset mid-grant
        for (int e = 1; e <= 20; e++) begin
            cyc(5'b00010);
            if (e == 1)  check("q_first", 32'(grant), 32'b00010);
            if (e == 5)  check("q_hc4", 32'(hold_count), 32'd4);
            if (e == 6)  check("q_to6", 32'(timeout), 32'd1);
            if (e == 6)  check("q_gap6", 32'(grant), 32'd0);
            if (e == 7)  check("q_regrant", 32'(grant), 32'b00010);
            if (e == 12) check("q_to12", 32'(timeout), 32'd1);
            if (e == 20) check("q_hc_e20", 32'(hold_count), 32'd1);
        end
        #2 reset = 1'b0;
        #1;
        check("async_grant", 32'(grant), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_to", 32'(timeout), 32'd0);
        check("async_owner", 32'(owner), 32'd0);
        cyc('0);
        reset = 1'b1;

        // Full contention rotation, every grant ending by timeout
        for (int k = 0; k < 7; k++) begin
            cyc(5'b11111);
            check("rot_owner", 32'(owner), 32'(k % N));
            check("rot_grant", 32'(grant), 32'(N'(1) << (k % N)));
            repeat (4) cyc(5'b11111);
            cyc(5'b11111);
            check("rot_to", 32'(timeout), 32'd1);
        end

        // Wrap and skip
        cyc(5'b01000);
        check("wrap_owner3", 32'(owner), 32'd3);
        cyc(5'b00101);
        check("wrap_release", 32'(grant), 32'd0);
        check("wrap_rel_noto", 32'(timeout), 32'd0);
        cyc(5'b00101);
        check("wrap_owner0", 32'(owner), 32'd0);
        repeat (4) cyc(5'b00101);
        cyc(5'b00101);
        check("wrap_to", 32'(timeout), 32'd1);
        cyc(5'b00101);
        check("skip_owner2", 32'(owner), 32'd2);

        // Release coinciding with expiry
        repeat (4) cyc(5'b00101);
        check("sim_hc4", 32'(hold_count), 32'd4);
        cyc(5'b00001);
        check("sim_grant", 32'(grant), 32'd0);
        check("sim_to", 32'(timeout), 32'd0);
        check("sim_busy", 32'(busy), 32'd0);
        cyc('0);
        cyc('0);

        // Randomized requests with occasional asynchronous resets
        r = '0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 25) r = N'($urandom);
            if ($urandom_range(0, 99) < 5) r = N'(1) << $urandom_range(0, N - 1);
            if ($urandom_range(0, 299) == 0) begin
                #2 reset = 1'b0;
                #1;
                check("rand_async_grant", 32'(grant), 32'd0);
                reset = 1'b1;
            end
            cyc(r);
        end
        cyc('0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/rr_slot_arbiter.md
Name: rr_slot_arbiter

Overview:
- Round-robin arbiter that shares one datapath resource (e.g. a mod-5 counter/register slice) among N requesters.
- Grants are time-bounded: each grant lasts at most QUANTUM cycles, tracked by an internal hold counter.
- Sits between requesting blocks and the shared resource. Drives a one-hot grant, the encoded owner, and a timeout pulse.

Parameters:
N, 5, number of requesters (2..8)
PTR_W, 3, width of owner/pointer encoding (must satisfy 2^PTR_W >= N)
QUANTUM, 5, maximum grant length in cycles (1..2^CNT_W)
CNT_W, 3, width of hold counter

Ports:
clock  input  1  single system clock, rising-edge
reset  input  1  asynchronous, active-low reset
req  input  N  level request per requester; held high while it wants the resource
grant  output  N  registered one-hot grant; all-zero when idle
owner  output  PTR_W  index of current grantee; holds last grantee when idle
busy  output  1  high while in GRANT state
hold_count  output  CNT_W  cycles elapsed in current grant (0..QUANTUM-1); 0 when idle
timeout  output  1  one-cycle pulse in the cycle after a grant is revoked by quantum expiry

Behaviour:
- Reset (reset=0, asynchronous, immediate):
  - state=IDLE; grant=0; owner=0; busy=0; hold_count=0; timeout=0.
  - Internal last-served pointer = N-1, so requester 0 has first priority.
- Reset asserted mid-grant: grant drops immediately without waiting for a clock edge; no timeout pulse.
- All outputs are registered. timeout defaults to 0 every cycle unless set as described below.
- IDLE:
  - At each edge, if req != 0, pick the first set bit searching last+1, last+2, ... with wrap modulo N (index N-1 wraps to 0).
  - At that edge: grant=onehot(pick), owner=pick, last=pick, busy=1, hold_count=0, state=GRANT.
  - Latency: req sampled high at edge k gives grant visible after edge k, i.e. one cycle of latency.
  - If req == 0, remain in IDLE with outputs unchanged, except timeout=0.
- GRANT, evaluated at each edge:
  - Voluntary release: if req[owner]=0, go to IDLE with grant=0, busy=0, hold_count=0, timeout=0.
  - Quantum expiry: else if hold_count==QUANTUM-1, go to IDLE with grant=0, busy=0, hold_count=0, timeout=1 for one cycle.
  - Otherwise: hold_count+1, grant held.
  - Voluntary release takes priority over expiry when both occur at the same edge; no timeout in that case.
  - req bits of non-owners are ignored during GRANT.
- Grant length and gaps:
  - A grant is high for at most QUANTUM consecutive cycles.
  - After any release there is exactly one dead cycle (IDLE, grant=0) before the next grant.
- Fairness:
  - A timed-out requester that keeps req high is not re-granted until every other pending requester has been served once.
  - If it is the only requester, it is re-granted after the dead cycle.
- QUANTUM=1: every grant lasts one cycle. timeout pulses whenever the owner's req is still high at the end of that cycle.
- owner is never out of range 0..N-1. grant is always one-hot or zero.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, release, req=0 for 5 cycles -> grant=00000, owner=0, busy=0, timeout=0 throughout; asserting reset mid-grant clears grant immediately without a clock edge.
- Single short request: req=00100 for 3 cycles, then 0 -> grant=00100 starting 1 cycle after req rises; hold_count 0,1,2; grant drops at the edge after req falls; timeout stays 0.
- Quantum expiry: req=00010 held for 20 cycles, QUANTUM=5 -> grant high 5 cycles (hold_count 0..4), then 1 cycle grant=0 with timeout=1; pattern repeats (5 on, 1 off).
- Full contention rotation: req=11111 held, each grant ends by timeout -> owner sequence 0,1,2,3,4,0,1, each with a 5-cycle grant and a 1-cycle gap.
- Wrap and skip: after owner=3 releases, req=00101 -> next owner=0 (search order 4,0); the following grant, with req still 00101, goes to owner=2.
- Simultaneous release and expiry: owner drops req exactly at the edge where hold_count=QUANTUM-1 -> grant=0, timeout=0, busy=0.
